// File: rtl/spi_ram_arbiter_pkg.sv
// Shared types and command-decode helpers for the SPI/host RAM command arbiter.
package spi_ram_arb_pkg;

   typedef enum logic [1:0] {
      OP_WR_ADDR = 2'b00,
      OP_WR_DATA = 2'b01,
      OP_RD_ADDR = 2'b10,
      OP_RD_DATA = 2'b11
   } opcode_e;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SPI_LOCK  = 2'd1,
      HOST_LOCK = 2'd2,
      RD_WAIT   = 2'd3
   } state_e;

   typedef enum logic {
      OWN_SPI  = 1'b0,
      OWN_HOST = 1'b1
   } owner_e;

   // Address-phase opcodes open a transaction; data-phase opcodes close it.
   function automatic logic is_opener(input logic [1:0] op);
      return (op == OP_WR_ADDR) || (op == OP_RD_ADDR);
   endfunction

   function automatic logic is_closer(input logic [1:0] op);
      return (op == OP_WR_DATA) || (op == OP_RD_DATA);
   endfunction

   function automatic logic is_read_close(input logic [1:0] op);
      return op == OP_RD_DATA;
   endfunction

endpackage

// File: rtl/spi_cmd_hold.sv
// One-entry holding buffer for SPI commands; the SPI side cannot be stalled,
// so a command arriving while the entry is occupied and not leaving is dropped.
module spi_cmd_hold #(
   parameter int CMD_W = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CMD_W-1:0] rx_data,
   input  logic             rx_valid,
   input  logic             drain,
   output logic             full,
   output logic [CMD_W-1:0] data,
   output logic             overrun
);

   assign overrun = rx_valid && full && !drain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full <= 1'b0;
         data <= '0;
      end else if (rx_valid && (!full || drain)) begin
         full <= 1'b1;
         data <= rx_data;
      end else if (drain) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Arbitrates the single-port RAM command path between the SPI slave (priority,
// non-stallable) and the host port, locking the grant across address/data pairs.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | no transaction open; SPI buffer first, else host
//   SPI_LOCK  | SPI opened a transaction; only the SPI buffer is drained
//   HOST_LOCK | host opened a transaction; SPI commands wait in the buffer
//   RD_WAIT   | read issued; waiting for RAM data to return to its owner
module spi_ram_arbiter
   import spi_ram_arb_pkg::*;
#(
   parameter int CMD_W        = 10,
   parameter int DATA_W       = 8,
   parameter int LOCK_TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CMD_W-1:0]  spi_rx_data,
   input  logic              spi_rx_valid,
   output logic [DATA_W-1:0] spi_tx_data,
   output logic              spi_tx_valid,
   input  logic [CMD_W-1:0]  h_cmd,
   input  logic              h_valid,
   output logic              h_ready,
   output logic [DATA_W-1:0] h_rdata,
   output logic              h_rvalid,
   output logic [CMD_W-1:0]  ram_din,
   output logic              ram_rx_valid,
   input  logic [DATA_W-1:0] ram_dout,
   input  logic              ram_tx_valid,
   input  logic              err_clr,
   output logic              err_overrun,
   output logic              err_timeout
);

   localparam int TMR_W = $clog2(LOCK_TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(LOCK_TIMEOUT - 1);

   state_e           state;
   owner_e           rd_owner;
   logic [TMR_W-1:0] timer;

   logic             hold_full;
   logic [CMD_W-1:0] hold_data;
   logic             overrun_evt;

   logic             drain;
   logic             take_host;
   logic             accept;
   logic [CMD_W-1:0] cmd;
   owner_e           src;
   logic [1:0]       op;
   logic             lock_idle;
   logic             timeout_evt;

   spi_cmd_hold #(.CMD_W(CMD_W)) u_hold (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx_data  (spi_rx_data),
      .rx_valid (spi_rx_valid),
      .drain    (drain),
      .full     (hold_full),
      .data     (hold_data),
      .overrun  (overrun_evt)
   );

   assign drain = hold_full && ((state == IDLE) || (state == SPI_LOCK));

   // Gated by rst_n so the host never sees a ready while the block is held in reset.
   assign h_ready = rst_n && ((state == HOST_LOCK) ||
                              ((state == IDLE) && !hold_full && !spi_rx_valid));

   assign take_host   = h_valid && h_ready && !drain;
   assign accept      = drain || take_host;
   assign cmd         = drain ? hold_data : h_cmd;
   assign src         = drain ? OWN_SPI : OWN_HOST;
   assign op          = cmd[CMD_W-1 -: 2];
   assign lock_idle   = ((state == SPI_LOCK) || (state == HOST_LOCK)) && !accept;
   assign timeout_evt = lock_idle && (timer == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         rd_owner     <= OWN_SPI;
         timer        <= '0;
         ram_din      <= '0;
         ram_rx_valid <= 1'b0;
         spi_tx_data  <= '0;
         spi_tx_valid <= 1'b0;
         h_rdata      <= '0;
         h_rvalid     <= 1'b0;
         err_overrun  <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         ram_rx_valid <= accept;
         if (accept) ram_din <= cmd;
         spi_tx_valid <= 1'b0;
         h_rvalid     <= 1'b0;

         case (state)
            IDLE, SPI_LOCK, HOST_LOCK: begin
               if (accept) begin
                  if (is_opener(op)) begin
                     state <= (src == OWN_SPI) ? SPI_LOCK : HOST_LOCK;
                     timer <= TMR_LOAD;
                  end else if (is_read_close(op)) begin
                     state    <= RD_WAIT;
                     rd_owner <= src;
                     timer    <= '0;
                  end else begin
                     state <= IDLE;
                     timer <= '0;
                  end
               end else if (lock_idle) begin
                  if (timer == '0) state <= IDLE;
                  else timer <= timer - 1'b1;
               end
            end
            RD_WAIT: begin
               if (ram_tx_valid) begin
                  if (rd_owner == OWN_SPI) begin
                     spi_tx_data  <= ram_dout;
                     spi_tx_valid <= 1'b1;
                  end else begin
                     h_rdata  <= ram_dout;
                     h_rvalid <= 1'b1;
                  end
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         // A new error event in the same cycle as err_clr keeps the flag set.
         if (overrun_evt)  err_overrun <= 1'b1;
         else if (err_clr) err_overrun <= 1'b0;
         if (timeout_evt)  err_timeout <= 1'b1;
         else if (err_clr) err_timeout <= 1'b0;
      end
   end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter with a transaction-level reference model
// compared on every falling edge, plus literal expectations at key points.
module tb_spi_ram_arbiter;

   localparam int CMD_W        = 10;
   localparam int DATA_W       = 8;
   localparam int LOCK_TIMEOUT = 64;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [CMD_W-1:0]  spi_rx_data = '0;
   logic              spi_rx_valid = 1'b0;
   logic [DATA_W-1:0] spi_tx_data;
   logic              spi_tx_valid;
   logic [CMD_W-1:0]  h_cmd = '0;
   logic              h_valid = 1'b0;
   logic              h_ready;
   logic [DATA_W-1:0] h_rdata;
   logic              h_rvalid;
   logic [CMD_W-1:0]  ram_din;
   logic              ram_rx_valid;
   logic [DATA_W-1:0] ram_dout = '0;
   logic              ram_tx_valid = 1'b0;
   logic              err_clr = 1'b0;
   logic              err_overrun;
   logic              err_timeout;

   always #5 clk = ~clk;

   spi_ram_arbiter #(.CMD_W(CMD_W), .DATA_W(DATA_W), .LOCK_TIMEOUT(LOCK_TIMEOUT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .spi_rx_data  (spi_rx_data),
      .spi_rx_valid (spi_rx_valid),
      .spi_tx_data  (spi_tx_data),
      .spi_tx_valid (spi_tx_valid),
      .h_cmd        (h_cmd),
      .h_valid      (h_valid),
      .h_ready      (h_ready),
      .h_rdata      (h_rdata),
      .h_rvalid     (h_rvalid),
      .ram_din      (ram_din),
      .ram_rx_valid (ram_rx_valid),
      .ram_dout     (ram_dout),
      .ram_tx_valid (ram_tx_valid),
      .err_clr      (err_clr),
      .err_overrun  (err_overrun),
      .err_timeout  (err_timeout)
   );

   int n_cmp = 0;
   int n_bad = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: lock owner 0 none / 1 spi / 2 host, pending read, idle run length.
   int               m_lock, m_rd_owner, m_idle, m_src;
   bit               m_rd, m_full, m_drain, m_take_host, m_acc, m_ovr_ev, m_to_ev;
   logic [CMD_W-1:0] m_hold, m_cmd;
   bit               e_ram_v, e_stv, e_hrv, e_ovr, e_to;
   logic [CMD_W-1:0] e_ram_din;
   logic [DATA_W-1:0] e_rdata;

   function automatic bit exp_hready();
      return rst_n && !m_rd && ((m_lock == 2) || (m_lock == 0 && !m_full && !spi_rx_valid));
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_lock = 0; m_rd = 0; m_rd_owner = 0; m_idle = 0; m_full = 0; m_hold = '0;
         e_ram_v = 0; e_ram_din = '0; e_stv = 0; e_hrv = 0; e_rdata = '0; e_ovr = 0; e_to = 0;
      end else begin
         m_drain     = m_full && !m_rd && (m_lock != 2);
         m_take_host = !m_drain && h_valid && exp_hready();
         m_acc       = m_drain || m_take_host;
         m_cmd       = m_drain ? m_hold : h_cmd;
         m_src       = m_drain ? 1 : 2;
         e_ram_v     = m_acc;
         if (m_acc) e_ram_din = m_cmd;
         e_stv = 0; e_hrv = 0; m_ovr_ev = 0; m_to_ev = 0;
         if (m_rd) begin
            if (ram_tx_valid) begin
               e_rdata = ram_dout;
               if (m_rd_owner == 1) e_stv = 1; else e_hrv = 1;
               m_rd = 0;
            end
         end else if (m_acc) begin
            case (m_cmd[9:8])
               2'b00, 2'b10: begin m_lock = m_src; m_idle = 0; end
               2'b01:        m_lock = 0;
               default:      begin m_lock = 0; m_rd = 1; m_rd_owner = m_src; end
            endcase
         end else if (m_lock != 0) begin
            m_idle++;
            if (m_idle == LOCK_TIMEOUT) begin m_lock = 0; m_to_ev = 1; end
         end
         if (spi_rx_valid) begin
            if (!m_full || m_drain) begin m_hold = spi_rx_data; m_full = 1; end
            else m_ovr_ev = 1;
         end else if (m_drain) begin
            m_full = 0;
         end
         e_ovr = m_ovr_ev ? 1'b1 : (err_clr ? 1'b0 : e_ovr);
         e_to  = m_to_ev  ? 1'b1 : (err_clr ? 1'b0 : e_to);
      end
   end

   logic [CMD_W-1:0] ram_log[$];
   logic [CMD_W-1:0] want[$];

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_ram_v", ram_rx_valid, 0);
         chk("rst_ram_din", ram_din, 0);
         chk("rst_spi_tx", {spi_tx_valid, spi_tx_data}, 0);
         chk("rst_h_r", {h_rvalid, h_rdata}, 0);
         chk("rst_h_ready", h_ready, 0);
         chk("rst_errs", {err_overrun, err_timeout}, 0);
      end else begin
         chk("ram_rx_valid", ram_rx_valid, e_ram_v);
         if (e_ram_v) chk("ram_din", ram_din, e_ram_din);
         chk("spi_tx_valid", spi_tx_valid, e_stv);
         if (e_stv) chk("spi_tx_data", spi_tx_data, e_rdata);
         chk("h_rvalid", h_rvalid, e_hrv);
         if (e_hrv) chk("h_rdata", h_rdata, e_rdata);
         chk("h_ready", h_ready, exp_hready());
         chk("err_overrun", err_overrun, e_ovr);
         chk("err_timeout", err_timeout, e_to);
         if (ram_rx_valid) ram_log.push_back(ram_din);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic spi_send(input logic [CMD_W-1:0] d);
      spi_rx_data  = d;
      spi_rx_valid = 1'b1;
      tick();
      spi_rx_valid = 1'b0;
   endtask

   task automatic host_send(input logic [CMD_W-1:0] d);
      bit acc;
      acc     = 0;
      h_cmd   = d;
      h_valid = 1'b1;
      for (int i = 0; i < 200 && !acc; i++) begin
         acc = h_ready;
         tick();
      end
      h_valid = 1'b0;
      if (!acc) begin
         n_cmp++;
         n_bad++;
         $display("FAIL host_accept: got no h_ready for cmd %0h expected acceptance", d);
      end
   endtask

   task automatic check_log(input string name);
      chk({name, "_len"}, ram_log.size(), want.size());
      for (int i = 0; i < want.size() && i < ram_log.size(); i++)
         chk($sformatf("%s_%0d", name, i), ram_log[i], want[i]);
      ram_log.delete();
      want.delete();
   endtask

   initial begin
      // reset and idle
      idle(3);
      chk("lit_rst_h_ready", h_ready, 0);
      rst_n = 1'b1;
      tick();
      chk("lit_idle_h_ready", h_ready, 1);

      // SPI write pair, no host traffic
      spi_send(10'h0A5);
      chk("lit_spi_buf_h_ready", h_ready, 0);
      chk("lit_spi_not_yet", ram_rx_valid, 0);
      tick();
      chk("lit_spi_fwd_v", ram_rx_valid, 1);
      chk("lit_spi_fwd_d", ram_din, 10'h0A5);
      spi_send(10'h155);
      idle(4);
      want = '{10'h0A5, 10'h155};
      check_log("log_spi_wr");
      chk("lit_spi_end_idle", h_ready, 1);

      // host write with SPI read arriving mid-transaction
      host_send(10'h012);
      spi_send(10'h2A7);
      host_send(10'h134);
      idle(4);
      spi_send(10'h355);
      idle(3);
      ram_dout = 8'hA5;
      ram_tx_valid = 1'b1;
      tick();
      ram_tx_valid = 1'b0;
      chk("lit_spi_rd_v", spi_tx_valid, 1);
      chk("lit_spi_rd_d", spi_tx_data, 8'hA5);
      chk("lit_spi_rd_h", h_rvalid, 0);
      idle(2);
      want = '{10'h012, 10'h134, 10'h2A7, 10'h355};
      check_log("log_mixed");
      chk("lit_no_overrun", err_overrun, 0);

      // stray RAM data in IDLE is ignored
      ram_dout = 8'h77;
      ram_tx_valid = 1'b1;
      tick();
      ram_tx_valid = 1'b0;
      tick();
      chk("lit_stray_rd", {h_rvalid, spi_tx_valid}, 0);

      // host read
      host_send(10'h205);
      host_send(10'h300);
      idle(2);
      ram_dout = 8'h3C;
      ram_tx_valid = 1'b1;
      tick();
      ram_tx_valid = 1'b0;
      chk("lit_h_rd_v", h_rvalid, 1);
      chk("lit_h_rd_d", h_rdata, 8'h3C);
      chk("lit_h_rd_spi", spi_tx_valid, 0);
      tick();
      chk("lit_h_rd_pulse1", h_rvalid, 0);
      idle(2);
      want = '{10'h205, 10'h300};
      check_log("log_h_rd");

      // lock timeout: 64 idle cycles after the opener
      host_send(10'h011);
      idle(LOCK_TIMEOUT - 1);
      chk("lit_to_edge_before", err_timeout, 0);
      tick();
      chk("lit_to_set", err_timeout, 1);
      chk("lit_to_idle", h_ready, 1);
      spi_send(10'h2FF);
      idle(3);
      want = '{10'h011, 10'h2FF};
      check_log("log_to");
      spi_send(10'h100);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("lit_to_clr", err_timeout, 0);
      idle(3);
      want = '{10'h100};
      check_log("log_to_close");

      // overrun under host lock; set wins over a simultaneous clear
      host_send(10'h000);
      spi_send(10'h0C3);
      err_clr = 1'b1;
      spi_send(10'h0D4);
      err_clr = 1'b0;
      chk("lit_ovr_set", err_overrun, 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("lit_ovr_clr", err_overrun, 0);
      host_send(10'h1AA);
      idle(3);
      spi_send(10'h155);
      idle(4);
      want = '{10'h000, 10'h1AA, 10'h0C3, 10'h155};
      check_log("log_ovr");

      // reset while waiting for read data
      host_send(10'h2AA);
      host_send(10'h3BB);
      idle(2);
      want = '{10'h2AA, 10'h3BB};
      check_log("log_pre_rst");
      rst_n = 1'b0;
      #1;
      chk("lit_rdw_rst_ready", h_ready, 0);
      chk("lit_rdw_rst_errs", {err_overrun, err_timeout}, 0);
      tick();
      rst_n = 1'b1;
      tick();
      ram_dout = 8'h99;
      ram_tx_valid = 1'b1;
      tick();
      ram_tx_valid = 1'b0;
      chk("lit_rdw_no_ret", {h_rvalid, spi_tx_valid}, 0);
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
